// File: rtl/rv_pkg.sv
// rv_pkg: shared opcode, counter and FSM definitions for the fetch-stage predictor.
// No ports. Holds the opcode[6:2] values of control instructions, the 2-bit
// counter encodings and the predictor FSM state type.
package rv_pkg;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/sat_ctr2.sv
// sat_ctr2: next-state function of a 2-bit saturating direction counter.
// Ports: ctr (current value), taken (resolved direction), force_st (jump:
// go straight to strongly taken), next (updated counter value).
module sat_ctr2
    import rv_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       force_st,
    output logic [1:0] next
);
    always_comb
        next = force_st ? CTR_ST :
               taken    ? ((ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1) :
                          ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped learning branch target buffer for fetch.
// Ports: clk/rst (sync, active high); pc/inst (fetch lookup);
// predict_pc/predict_taken/predict_hit (combinational prediction);
// init_busy (valid-bit clear sweep running); upd_* (execute-stage training).
module btb_predictor
    import rv_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] predict_pc,
    output logic        predict_taken,
    output logic        predict_hit,
    output logic        init_busy,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_jump
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [1:0]         ctrs    [ENTRIES];
    state_t             state;
    logic [IDX_W-1:0]   sweep;
    logic [IDX_W-1:0]   idx, uidx;
    logic [TAG_W-1:0]   tag, utag;
    logic               ctl, uhit;
    logic [1:0]         ctr_next;
    logic               unused_bits;

    assign idx  = pc[IDX_W+1:2];
    assign tag  = pc[31:IDX_W+2];
    assign uidx = upd_pc[IDX_W+1:2];
    assign utag = upd_pc[31:IDX_W+2];
    assign unused_bits = ^{pc[1:0], upd_pc[1:0], inst[31:7], inst[1:0]};

    always_comb begin
        ctl           = (inst[6:2] == OP_BRANCH) | (inst[6:2] == OP_JAL) | (inst[6:2] == OP_JALR);
        init_busy     = (state == INIT);
        predict_hit   = ctl & ~init_busy & valid[idx] & (tags[idx] == tag);
        predict_taken = predict_hit & ctrs[idx][1];
        predict_pc    = predict_taken ? targets[idx] : pc + 32'd4;
        uhit          = valid[uidx] & (tags[uidx] == utag);
    end

    sat_ctr2 u_ctr (
        .ctr      (ctrs[uidx]),
        .taken    (upd_taken),
        .force_st (upd_jump),
        .next     (ctr_next)
    );

    // Only valid bits are cleared; tag/target/ctr are don't-care until allocated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            sweep <= '0;
        end else if (state == INIT) begin
            valid[sweep] <= 1'b0;
            sweep        <= sweep + 1'b1;
            if (sweep == IDX_W'(ENTRIES - 1))
                state <= RUN;
        end else if (upd_valid) begin
            if (uhit) begin
                ctrs[uidx] <= ctr_next;
                if (upd_taken | upd_jump)
                    targets[uidx] <= upd_target;
            end else if (upd_taken | upd_jump) begin
                valid[uidx]   <= 1'b1;
                tags[uidx]    <= utag;
                targets[uidx] <= upd_target;
                ctrs[uidx]    <= upd_jump ? CTR_ST : CTR_INIT;
            end
        end
    end
endmodule
